// File: rtl/y86_mon_pkg.sv
// Shared encodings for the Y86 run monitor: processor status, monitor FSM
// states and the Y86-64 instruction codes.
package y86_mon_pkg;

    typedef enum logic [1:0] {
        ST_AOK = 2'd0,
        ST_HLT = 2'd1,
        ST_ADR = 2'd2,
        ST_INS = 2'd3
    } y86_status_e;

    typedef enum logic [2:0] {
        RS_IDLE    = 3'd0,
        RS_RUN     = 3'd1,
        RS_HALTED  = 3'd2,
        RS_FAULT   = 3'd3,
        RS_TIMEOUT = 3'd4
    } run_state_e;

    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

endpackage

// File: rtl/y86_mon_trace_buf.sv
// Circular buffer of the most recently retired PCs; rd_idx 0 is the newest
// entry and entries not yet written since the last clear read as 0.
module y86_mon_trace_buf #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [63:0]      pc_in,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_pc
);

    logic [63:0]      mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= pc_in;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    // wr_ptr points at the next free slot, so the newest entry sits one behind it
    assign rd_ptr = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_pc  = mem[rd_ptr];

endmodule

// File: rtl/y86_run_monitor.sv
// Run monitor for a Y86 core: tracks one run from start to halt, fault or
// timeout, with saturating counters. Optional PC trace via Y86_MON_TRACE_EN.
//
// state   | meaning
// IDLE    | no run since reset
// RUN     | counting cycles and retiring instructions
// HALTED  | halt instruction retired (pass)
// FAULT   | ADR/INS status or illegal fetch
// TIMEOUT | cycle budget exhausted
module y86_run_monitor
    import y86_mon_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 440,
    parameter int CNT_W          = 32,
    parameter int N_ICODE        = 12,
    parameter int TRACE_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [1:0]                     status,
    input  logic                           instr_valid,
    input  logic [3:0]                     icode,
    input  logic [63:0]                    PC,
    input  logic [3:0]                     cnt_sel,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [2:0]                     run_state,
    output logic                           done,
    output logic                           pass,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [CNT_W-1:0]               instr_cnt,
    output logic [CNT_W-1:0]               icode_cnt,
    output logic [63:0]                    last_pc,
    output logic [63:0]                    trace_pc
);

    // A budget beyond the saturated counter range can never be reached
    localparam bit TO_REACHABLE = (CNT_W >= 31) || ((TIMEOUT_CYCLES - 1) < (1 << CNT_W));
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    run_state_e       state;
    logic [CNT_W-1:0] icode_cnt_q [N_ICODE];
    logic             is_fault;
    logic             is_halt;
    logic             is_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign is_fault = !instr_valid || status == ST_ADR || status == ST_INS;
    assign is_halt  = status == ST_HLT;
    assign is_last  = TO_REACHABLE && (cycle_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RS_IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            last_pc   <= '0;
            for (int i = 0; i < N_ICODE; i++) icode_cnt_q[i] <= '0;
        end else begin
            case (state)
                RS_RUN: begin
                    cycle_cnt <= sat_inc(cycle_cnt);
                    if (is_fault) begin
                        state <= RS_FAULT;
                        done  <= 1'b1;
                    end else begin
                        instr_cnt <= sat_inc(instr_cnt);
                        last_pc   <= PC;
                        for (int i = 0; i < N_ICODE; i++)
                            if (icode == 4'(i)) icode_cnt_q[i] <= sat_inc(icode_cnt_q[i]);
                        if (is_halt) begin
                            state <= RS_HALTED;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else if (is_last) begin
                            state <= RS_TIMEOUT;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state     <= RS_RUN;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        cycle_cnt <= '0;
                        instr_cnt <= '0;
                        last_pc   <= '0;
                        for (int i = 0; i < N_ICODE; i++) icode_cnt_q[i] <= '0;
                    end
                end
            endcase
        end
    end

    assign run_state = state;

    always_comb begin
        icode_cnt = '0;
        for (int i = 0; i < N_ICODE; i++)
            if (cnt_sel == 4'(i)) icode_cnt = icode_cnt_q[i];
    end

`ifdef Y86_MON_TRACE_EN
    logic trace_clear;
    logic trace_push;

    assign trace_clear = (state != RS_RUN) && start;
    assign trace_push  = (state == RS_RUN) && !is_fault;

    y86_mon_trace_buf #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (trace_clear),
        .push   (trace_push),
        .pc_in  (PC),
        .rd_idx (trace_idx),
        .rd_pc  (trace_pc)
    );
`else
    logic unused_trace;
    assign unused_trace = ^trace_idx;
    assign trace_pc     = '0;
`endif

endmodule

// File: tb/tb_y86_run_monitor.sv
// Directed bench for y86_run_monitor: default, short-timeout and narrow-counter
// instances driven from shared stimulus with per-instance start pulses.
module tb_y86_run_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [1:0]  status = 2'd0;
    logic        instr_valid = 1'b1;
    logic [3:0]  icode = 4'd1;
    logic [63:0] pc = 64'd0;
    logic [3:0]  cnt_sel = 4'd0;
    logic [1:0]  trace_idx_a = 2'd0;
    logic [2:0]  trace_idx_bc = 3'd0;

    logic [2:0]  rs_a, rs_b, rs_c;
    logic        done_a, done_b, done_c, pass_a, pass_b, pass_c;
    logic [31:0] cyc_a, ins_a, icn_a, cyc_b, ins_b, icn_b;
    logic [2:0]  cyc_c, ins_c, icn_c;
    logic [63:0] lpc_a, tpc_a, lpc_b, tpc_b, lpc_c, tpc_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    y86_run_monitor #(.TRACE_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .status(status),
        .instr_valid(instr_valid), .icode(icode), .PC(pc), .cnt_sel(cnt_sel),
        .trace_idx(trace_idx_a), .run_state(rs_a), .done(done_a), .pass(pass_a),
        .cycle_cnt(cyc_a), .instr_cnt(ins_a), .icode_cnt(icn_a),
        .last_pc(lpc_a), .trace_pc(tpc_a));

    y86_run_monitor #(.TIMEOUT_CYCLES(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .status(status),
        .instr_valid(instr_valid), .icode(icode), .PC(pc), .cnt_sel(cnt_sel),
        .trace_idx(trace_idx_bc), .run_state(rs_b), .done(done_b), .pass(pass_b),
        .cycle_cnt(cyc_b), .instr_cnt(ins_b), .icode_cnt(icn_b),
        .last_pc(lpc_b), .trace_pc(tpc_b));

    y86_run_monitor #(.CNT_W(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .status(status),
        .instr_valid(instr_valid), .icode(icode), .PC(pc), .cnt_sel(cnt_sel),
        .trace_idx(trace_idx_bc), .run_state(rs_c), .done(done_c), .pass(pass_c),
        .cycle_cnt(cyc_c), .instr_cnt(ins_c), .icode_cnt(icn_c),
        .last_pc(lpc_c), .trace_pc(tpc_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] st, input logic v, input logic [3:0] ic, input logic [63:0] p);
        status = st; instr_valid = v; icode = ic; pc = p;
        tick();
    endtask

    task automatic go(input int which);
        status = 2'd0; instr_valid = 1'b1;
        if (which == 0) start_a = 1'b1;
        else if (which == 1) start_b = 1'b1;
        else start_c = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_state", rs_a, 3'd0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_pass", pass_a, 1'b0);
        chk("rst_cycle", cyc_a, 0);
        chk("rst_instr", ins_a, 0);
        chk("rst_lastpc", lpc_a, 0);
        chk("rst_trace", tpc_a, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // five AOK (one with out-of-range icode 13) then halt
        go(0);
        chk("run_state", rs_a, 3'd1);
        cyc(2'd0, 1, 4'd1,  64'h100);
        cyc(2'd0, 1, 4'd1,  64'h10A);
        cyc(2'd0, 1, 4'd3,  64'h114);
        cyc(2'd0, 1, 4'd13, 64'h11E);
        cyc(2'd0, 1, 4'd6,  64'h128);
        cyc(2'd1, 1, 4'd0,  64'h200);
        chk("halt_state", rs_a, 3'd2);
        chk("halt_done", done_a, 1'b1);
        chk("halt_pass", pass_a, 1'b1);
        chk("halt_instr", ins_a, 6);
        cnt_sel = 4'd1;  #1 chk("icnt_nop", icn_a, 2);
        cnt_sel = 4'd3;  #1 chk("icnt_irmov", icn_a, 1);
        cnt_sel = 4'd6;  #1 chk("icnt_opq", icn_a, 1);
        cnt_sel = 4'd0;  #1 chk("icnt_halt", icn_a, 1);
        cnt_sel = 4'd13; #1 chk("icnt_oob", icn_a, 0);
        chk("halt_cycle", cyc_a, 6);
        chk("halt_lastpc", lpc_a, 64'h200);
        cyc(2'd2, 0, 4'd2, 64'h999);
        cyc(2'd0, 1, 4'd2, 64'h998);
        chk("hold_state", rs_a, 3'd2);
        chk("hold_instr", ins_a, 6);
        chk("hold_cycle", cyc_a, 6);
        chk("hold_lastpc", lpc_a, 64'h200);

        // three AOK then INS, with a start pulse mid-run that must be ignored
        go(0);
        chk("restart_instr", ins_a, 0);
        cyc(2'd0, 1, 4'd1, 64'h40);
        start_a = 1'b1;
        cyc(2'd0, 1, 4'd1, 64'h41);
        start_a = 1'b0;
        cyc(2'd0, 1, 4'd1, 64'h42);
        cyc(2'd3, 1, 4'd1, 64'h43);
        chk("ins_state", rs_a, 3'd3);
        chk("ins_done", done_a, 1'b1);
        chk("ins_pass", pass_a, 1'b0);
        chk("ins_instr", ins_a, 3);
        chk("ins_cycle", cyc_a, 4);
        chk("ins_lastpc", lpc_a, 64'h42);

        // illegal fetch faults without retiring
        go(0);
        cyc(2'd0, 1, 4'd1, 64'h50);
        cyc(2'd0, 0, 4'd1, 64'h51);
        chk("inv_state", rs_a, 3'd3);
        chk("inv_instr", ins_a, 1);
        chk("inv_cycle", cyc_a, 2);

        // timeout budget of 10
        go(1);
        for (int i = 0; i < 9; i++) cyc(2'd0, 1, 4'd1, 64'(i));
        chk("to_pre_state", rs_b, 3'd1);
        chk("to_pre_cycle", cyc_b, 9);
        cyc(2'd0, 1, 4'd1, 64'h9);
        chk("to_state", rs_b, 3'd4);
        chk("to_done", done_b, 1'b1);
        chk("to_pass", pass_b, 1'b0);
        chk("to_cycle", cyc_b, 10);
        chk("to_instr", ins_b, 10);

        go(1);
        for (int i = 0; i < 9; i++) cyc(2'd0, 1, 4'd1, 64'(i));
        cyc(2'd1, 1, 4'd0, 64'h77);
        chk("to_hlt_state", rs_b, 3'd2);
        chk("to_hlt_pass", pass_b, 1'b1);
        chk("to_hlt_cycle", cyc_b, 10);

        go(1);
        for (int i = 0; i < 9; i++) cyc(2'd0, 1, 4'd1, 64'(i));
        cyc(2'd2, 1, 4'd1, 64'h78);
        chk("to_adr_state", rs_b, 3'd3);
        chk("to_adr_instr", ins_b, 9);

        // 3-bit counters saturate at 7
        go(2);
        for (int i = 0; i < 9; i++) cyc(2'd0, 1, 4'd1, 64'(i));
        cyc(2'd1, 1, 4'd0, 64'h80);
        chk("sat_state", rs_c, 3'd2);
        chk("sat_instr", ins_c, 7);
        chk("sat_cycle", cyc_c, 7);
        cnt_sel = 4'd1; #1 chk("sat_icnt", icn_c, 7);
        go(2);
        chk("sat_clr_instr", ins_c, 0);
        chk("sat_clr_cycle", cyc_c, 0);
        chk("sat_clr_state", rs_c, 3'd1);

        // PC trace over a four-entry buffer
        go(0);
        cyc(2'd0, 1, 4'd1, 64'h0);
        cyc(2'd0, 1, 4'd1, 64'hA);
        cyc(2'd0, 1, 4'd1, 64'h14);
        cyc(2'd0, 1, 4'd1, 64'h1E);
        cyc(2'd1, 1, 4'd0, 64'h28);
`ifdef Y86_MON_TRACE_EN
        trace_idx_a = 2'd0; #1 chk("trace0", tpc_a, 64'h28);
        trace_idx_a = 2'd1; #1 chk("trace1", tpc_a, 64'h1E);
        trace_idx_a = 2'd2; #1 chk("trace2", tpc_a, 64'h14);
        trace_idx_a = 2'd3; #1 chk("trace3", tpc_a, 64'hA);
`else
        for (int i = 0; i < 4; i++) begin
            trace_idx_a = 2'(i);
            #1 chk("trace_off", tpc_a, 0);
        end
`endif

        // asynchronous reset mid-run
        go(0);
        cyc(2'd0, 1, 4'd1, 64'h90);
        cyc(2'd0, 1, 4'd1, 64'h94);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", rs_a, 3'd0);
        chk("arst_done", done_a, 1'b0);
        chk("arst_cycle", cyc_a, 0);
        chk("arst_instr", ins_a, 0);
        chk("arst_lastpc", lpc_a, 0);
        chk("arst_trace", tpc_a, 0);
        #1 rst_n = 1'b1;
        tick();
        go(0);
        cyc(2'd0, 1, 4'd1, 64'hA0);
        cyc(2'd1, 1, 4'd0, 64'hA4);
        chk("post_rst_state", rs_a, 3'd2);
        chk("post_rst_instr", ins_a, 2);
        chk("post_rst_lastpc", lpc_a, 64'hA4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
